// File: rtl/dmem_access_ctrl.sv
// Load/store front end for a word-wide data memory: subword access via
// read-modify-write, lane extraction with sign/zero extension, misalignment errors.
module dmem_access_ctrl #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic          mem_re,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]        state, state_nxt;
    logic              we_q, we_nxt;
    logic [1:0]        size_q, size_nxt;
    logic              sgn_q, sgn_nxt;
    logic [1:0]        off_q, off_nxt;
    logic [HALF_W-1:0] wdata_q, wdata_nxt;

    logic              req_ready_nxt;
    logic              resp_valid_nxt;
    logic [DW-1:0]     resp_rdata_nxt;
    logic              resp_err_nxt;
    logic              mem_re_nxt;
    logic              mem_we_nxt;
    logic [AW-1:0]     mem_a_nxt;
    logic [DW-1:0]     mem_wd_nxt;

    logic              misaligned;
    logic [4:0]        byte_sh;
    logic [4:0]        half_sh;
    logic [BYTE_W-1:0] lane_b;
    logic [HALF_W-1:0] lane_h;
    logic [DW-1:0]     load_data;
    logic [DW-1:0]     merged_word;

    // Alignment rule for the incoming request; reserved size always errors
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = req_addr[0];
            SZ_WORD: misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    assign byte_sh = {off_q, 3'b000};
    assign half_sh = {off_q[1], 4'b0000};

    // Lane extraction and extension of the word read from memory
    always_comb begin
        lane_b    = mem_rd[byte_sh +: BYTE_W];
        lane_h    = mem_rd[half_sh +: HALF_W];
        load_data = mem_rd;
        case (size_q)
            SZ_BYTE: load_data = {{(DW-BYTE_W){sgn_q & lane_b[BYTE_W-1]}}, lane_b};
            SZ_HALF: load_data = {{(DW-HALF_W){sgn_q & lane_h[HALF_W-1]}}, lane_h};
            default: load_data = mem_rd;
        endcase
    end

    // Read-modify-write merge of subword store data into the read word
    always_comb begin
        merged_word = mem_rd;
        if (size_q == SZ_HALF) begin
            merged_word[half_sh +: HALF_W] = wdata_q;
        end else begin
            merged_word[byte_sh +: BYTE_W] = wdata_q[BYTE_W-1:0];
        end
    end

    // Next-state and next-output logic; every output is registered from here
    always_comb begin
        state_nxt      = state;
        we_nxt         = we_q;
        size_nxt       = size_q;
        sgn_nxt        = sgn_q;
        off_nxt        = off_q;
        wdata_nxt      = wdata_q;
        resp_valid_nxt = 1'b0;
        resp_rdata_nxt = '0;
        resp_err_nxt   = 1'b0;
        mem_re_nxt     = 1'b0;
        mem_we_nxt     = 1'b0;
        mem_a_nxt      = mem_a;
        mem_wd_nxt     = mem_wd;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    we_nxt    = req_we;
                    size_nxt  = req_size;
                    sgn_nxt   = req_signed;
                    off_nxt   = req_addr[1:0];
                    wdata_nxt = req_wdata[HALF_W-1:0];
                    mem_a_nxt = {req_addr[AW-1:2], 2'b00};
                    if (misaligned) begin
                        state_nxt      = RESP;
                        resp_valid_nxt = 1'b1;
                        resp_err_nxt   = 1'b1;
                    end else if (!req_we || (req_size != SZ_WORD)) begin
                        state_nxt  = RD;
                        mem_re_nxt = 1'b1;
                    end else begin
                        state_nxt  = WR;
                        mem_we_nxt = 1'b1;
                        mem_wd_nxt = req_wdata;
                    end
                end
            end
            RD: begin
                if (!we_q) begin
                    state_nxt      = RESP;
                    resp_valid_nxt = 1'b1;
                    resp_rdata_nxt = load_data;
                end else begin
                    state_nxt  = WR;
                    mem_we_nxt = 1'b1;
                    mem_wd_nxt = merged_word;
                end
            end
            WR: begin
                state_nxt      = RESP;
                resp_valid_nxt = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        req_ready_nxt = (state_nxt == IDLE);
    end

    // State, captured request and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            sgn_q      <= 1'b0;
            off_q      <= 2'b00;
            wdata_q    <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_a      <= '0;
            mem_wd     <= '0;
        end else begin
            state      <= state_nxt;
            we_q       <= we_nxt;
            size_q     <= size_nxt;
            sgn_q      <= sgn_nxt;
            off_q      <= off_nxt;
            wdata_q    <= wdata_nxt;
            req_ready  <= req_ready_nxt;
            resp_valid <= resp_valid_nxt;
            resp_rdata <= resp_rdata_nxt;
            resp_err   <= resp_err_nxt;
            mem_re     <= mem_re_nxt;
            mem_we     <= mem_we_nxt;
            mem_a      <= mem_a_nxt;
            mem_wd     <= mem_wd_nxt;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed cases plus randomized requests against
// an arithmetic reference model of memory and load/store semantics.
module tb_dmem_access_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NW = 4096;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_signed = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    logic [31:0] mem     [NW];
    logic [31:0] ref_mem [NW];

    int total = 0;
    int bad = 0;
    int we_pulses = 0;
    int both_hi = 0;
    logic [31:0] last_rdata;

    dmem_access_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_re(mem_re), .mem_we(mem_we), .mem_a(mem_a),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[13:2]];

    // Memory write port and bus activity monitor
    always @(posedge clk) begin
        if (mem_we) begin
            we_pulses = we_pulses + 1;
            mem[mem_a[13:2]] = mem_wd;
        end
        if (mem_re && mem_we) both_hi = both_hi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic bit ref_mis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz == 2'd2) return (a % 4) != 0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                             input bit sg, input logic [31:0] a);
        longint unsigned base, span, v;
        if (sz == 2'd2) return w;
        base = 64'(1) << (8 * int'(a % 4));
        span = (sz == 2'd0) ? 64'd256 : 64'd65536;
        v = (64'(w) / base) % span;
        if (sg && v >= span / 2) v = v + 64'h1_0000_0000 - span;
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] wd);
        longint unsigned base, span, oldv, nw;
        if (sz == 2'd2) return wd;
        base = 64'(1) << (8 * int'(a % 4));
        span = (sz == 2'd0) ? 64'd256 : 64'd65536;
        oldv = (64'(w) / base) % span;
        nw = 64'(w) - oldv * base + (64'(wd) % span) * base;
        return 32'(nw);
    endfunction

    task automatic setw(input logic [31:0] a, input logic [31:0] v);
        mem[a[13:2]] = v;
        ref_mem[a[13:2]] = v;
    endtask

    task automatic scramble_inputs();
        req_valid  = 1'($urandom);
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = 32'($urandom_range(0, 16383));
        req_wdata  = $urandom;
    endtask

    // One request from IDLE through the response; called at posedge+1
    task automatic run_req(input string tag, input bit we, input logic [1:0] sz, input bit sg,
                           input logic [31:0] a, input logic [31:0] wd);
        int idx, lat, wp0, op, exp_op;
        bit mis;
        logic [31:0] exp_rd, exp_wd, exp_mem;
        idx = int'(a[13:2]);
        mis = ref_mis(sz, a);
        if (mis) lat = 1;
        else if (!we || sz == 2'd2) lat = 2;
        else lat = 3;
        exp_rd  = (!mis && !we) ? ref_load(ref_mem[idx], sz, sg, a) : 32'd0;
        exp_wd  = ref_store(ref_mem[idx], sz, a, wd);
        exp_mem = (!mis && we) ? exp_wd : ref_mem[idx];
        wp0 = we_pulses;

        chk({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        for (int k = 1; k <= lat; k++) begin
            if (k == lat) req_valid = 1'b0;
            else scramble_inputs();
            if (mis) exp_op = 0;
            else if (!we) exp_op = (k == 1) ? 1 : 0;
            else if (sz == 2'd2) exp_op = (k == 1) ? 2 : 0;
            else exp_op = (k == 1) ? 1 : ((k == 2) ? 2 : 0);
            op = int'({mem_we, mem_re});
            chk($sformatf("%s.c%0d.op", tag, k), 32'(op), 32'(exp_op));
            chk($sformatf("%s.c%0d.valid", tag, k), 32'(resp_valid), 32'(k == lat));
            chk($sformatf("%s.c%0d.ready", tag, k), 32'(req_ready), 32'd0);
            if (exp_op != 0) chk($sformatf("%s.c%0d.mem_a", tag, k), mem_a, {a[31:2], 2'b00});
            if (exp_op == 2) chk($sformatf("%s.c%0d.mem_wd", tag, k), mem_wd, exp_wd);
            if (k == lat) begin
                last_rdata = resp_rdata;
                chk({tag, ".rdata"}, resp_rdata, exp_rd);
                chk({tag, ".err"}, 32'(resp_err), 32'(mis));
            end
            if (k < lat) begin
                @(posedge clk); #1;
            end
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".valid_after"}, 32'(resp_valid), 32'd0);
        chk({tag, ".ready_after"}, 32'(req_ready), 32'd1);
        chk({tag, ".we_pulses"}, 32'(we_pulses - wp0), 32'(!mis && we));
        chk({tag, ".memword"}, mem[idx], exp_mem);
        ref_mem[idx] = exp_mem;
    endtask

    initial begin
        logic [31:0] v, a;
        logic [1:0] sz;
        bit we, sg;
        int wp0;
        for (int i = 0; i < int'(NW); i++) begin
            v = $urandom;
            mem[i] = v;
            ref_mem[i] = v;
        end

        #3 reset_n = 1'b0;
        #1;
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.valid", 32'(resp_valid), 32'd0);
        chk("rst.err", 32'(resp_err), 32'd0);
        chk("rst.rdata", resp_rdata, 32'd0);
        chk("rst.re_we", 32'({mem_re, mem_we}), 32'd0);
        chk("rst.mem_a", mem_a, 32'd0);
        chk("rst.mem_wd", mem_wd, 32'd0);
        #18 reset_n = 1'b1;
        @(posedge clk); #1;

        setw(32'h1000, 32'h11223344);
        run_req("sb1001", 1'b1, 2'd0, 1'b0, 32'h1001, 32'hFFFFFFAB);
        chk("sb1001.word", mem[32'h1000 >> 2], 32'h1122AB44);

        setw(32'h1004, 32'h8001FFFF);
        run_req("lhs1006", 1'b0, 2'd1, 1'b1, 32'h1006, 32'h0);
        chk("lhs1006.val", last_rdata, 32'hFFFF8001);
        run_req("lhu1006", 1'b0, 2'd1, 1'b0, 32'h1006, 32'h0);
        chk("lhu1006.val", last_rdata, 32'h00008001);

        setw(32'h20, 32'h80FF7F01);
        run_req("lb20", 1'b0, 2'd0, 1'b1, 32'h20, 32'h0);
        chk("lb20.val", last_rdata, 32'h00000001);
        run_req("lb21", 1'b0, 2'd0, 1'b1, 32'h21, 32'h0);
        chk("lb21.val", last_rdata, 32'h0000007F);
        run_req("lb22", 1'b0, 2'd0, 1'b1, 32'h22, 32'h0);
        chk("lb22.val", last_rdata, 32'hFFFFFFFF);
        run_req("lb23", 1'b0, 2'd0, 1'b1, 32'h23, 32'h0);
        chk("lb23.val", last_rdata, 32'hFFFFFF80);

        run_req("sw40", 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF);
        run_req("lw40", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        chk("lw40.val", last_rdata, 32'hDEADBEEF);

        run_req("mis_sw42", 1'b1, 2'd2, 1'b0, 32'h42, 32'h12345678);
        run_req("mis_lh43", 1'b0, 2'd1, 1'b1, 32'h43, 32'h0);
        run_req("mis_sz3", 1'b0, 2'd3, 1'b0, 32'h44, 32'h0);

        // Reset during the read phase of a subword store
        setw(32'h300, 32'hCAFEF00D);
        wp0 = we_pulses;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h301; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstmid.re_in_rd", 32'(mem_re), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rstmid.re_drop", 32'(mem_re), 32'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rstmid.ready", 32'(req_ready), 32'd1);
        chk("rstmid.valid", 32'(resp_valid), 32'd0);
        chk("rstmid.no_we", 32'(we_pulses - wp0), 32'd0);
        chk("rstmid.word", mem[32'h300 >> 2], 32'hCAFEF00D);

        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom);
            sg = 1'($urandom);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 16383));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a = a - (a % 2);
                if (sz == 2'd2) a = a - (a % 4);
            end
            run_req($sformatf("rnd%0d", n), we, sz, sg, a, $urandom);
        end

        chk("never_re_and_we", 32'(both_hi), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Load/store front end sitting directly upstream of the word-wide data memory.
- Accepts byte, halfword and word requests from the pipeline memory stage over a valid/ready handshake.
- Turns them into word-aligned memory reads and writes; subword stores use read-modify-write.
- Returns lane-aligned, sign- or zero-extended load data, plus an error flag for misaligned requests.

Parameters:
AW, 32, address width of request and memory buses
DW, 32, data width; fixed 4 byte lanes, only DW=32 supported

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept request
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned)
req_signed  in  1  sign-extend loads (ignored for word and for stores)
req_addr  in  AW  byte address
req_wdata  in  DW  store data, right-justified
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  DW  load data (0 for stores and errors)
resp_err  out  1  misaligned/reserved request
mem_re  out  1  memory read enable
mem_we  out  1  memory write enable
mem_a  out  AW  word address, bits [1:0] always 0
mem_wd  out  DW  memory write data
mem_rd  in  DW  memory read data, combinational from mem_a

Behaviour:
- Reset (async, reset_n=0): state IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0, mem_re=0, mem_we=0, mem_a=0, mem_wd=0; all captured request registers cleared. Reset mid-operation abandons the operation with no memory write; a write already committed on an earlier edge stands.
- Byte lanes are little-endian: lane n = bits [8n+7:8n], selected by addr[1:0].
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready=1. On req_valid, capture the request. Transitions:
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, size 11): go to RESP with err=1.
  - Load or subword store: go to RD.
  - Word store: go to WR.
- RD: mem_re=1, mem_a={addr[AW-1:2],2'b00}; capture mem_rd at clock edge.
  - Load: extract lane(s), extend per req_signed/size, go to RESP.
  - Subword store: merge req_wdata low byte/half into captured word at addressed lane(s), go to WR.
- WR: mem_we=1, mem_a=word address, mem_wd = merged word (subword) or req_wdata (word). Go to RESP.
- RESP: resp_valid=1 for exactly one cycle; resp_rdata valid for loads, else 0; resp_err as captured. Go to IDLE.
- req_ready=0 in all states except IDLE; no back-to-back acceptance (one request in flight).
- Latency, from the accept edge to the resp_valid cycle:
  - Misaligned: 1 cycle.
  - Word store: 2 cycles.
  - Load: 2 cycles.
  - Subword store: 3 cycles.
- mem_re and mem_we never both 1. Both are 0 outside RD/WR. Errors never touch memory.
- Extension: byte signed replicates bit 7, halfword signed replicates bit 15; unsigned zero-fills. Word loads pass through unmodified.
- req_* inputs are ignored while req_ready=0; the bench may change them freely.

Test Plan:
- Byte store: memory word 0x1000 = 0x11223344; store byte 0xAB (req_wdata=0xFFFFFFAB) to 0x1001 → RD then WR cycle with mem_a=0x1000, mem_wd=0x1122AB44; resp_valid 3 cycles after accept, err=0, rdata=0.
- Signed half load: word 0x1004 = 0x8001FFFF; load half signed at 0x1006 → mem_re at 0x1004, resp_rdata=0xFFFF8001 two cycles after accept. Same load unsigned → 0x00008001.
- Byte loads across lanes: word 0x20 = 0x80FF7F01; load signed byte at 0x20/0x21/0x22/0x23 → 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
- Word store then load: store 0xDEADBEEF to 0x40 → mem_we one cycle with mem_wd=0xDEADBEEF, resp after 2 cycles; following load from 0x40 → rdata=0xDEADBEEF.
- Misaligned: word store to 0x42, half load from 0x43, size=11 → resp_err=1 one cycle after accept, rdata=0; mem_we and mem_re stay 0 throughout.
- Reset mid-op: assert reset_n=0 during RD of a subword store → mem_re drops immediately, no mem_we ever pulses, memory word unchanged; after release req_ready=1 and resp_valid=0.
